prng: RTL and testbench



---
 rtl/prng_pkg.sv | 24 ++
 rtl/prng_feedback.sv | 24 ++
 rtl/prng.sv | 62 ++++++
 tb/tb_prng.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// prng_pkg: shared widths, tap positions and types for the 10-bit
// Fibonacci LFSR noise source (x^10 + x^7 + 1, XNOR feedback).
// Contents:
//   PRNG_W        register width
//   TAP_HI/TAP_LO feedback tap bit positions
//   prn_t         LFSR state type
//   LOCKUP_STATE  the one state an XNOR LFSR cannot leave
//   guard_seed()  maps the lock-up state to zero; used only when the
//                 PRNG_LOCKUP_GUARD_EN macro is defined
package prng_pkg;

  localparam int PRNG_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;

  typedef logic [PRNG_W-1:0] prn_t;

  localparam prn_t LOCKUP_STATE = 10'h3FF;

  function automatic prn_t guard_seed(input prn_t seed);
    return (seed == LOCKUP_STATE) ? prn_t'(0) : seed;
  endfunction

endpackage

// File: rtl/prng_feedback.sv
// prng_feedback: combinational next-state function of the LFSR.
// Ports:
//   state_i  current LFSR state
//   next_o   state after one shift
// Macro PRNG_LOCKUP_GUARD_EN: when defined, the lock-up state steps to zero
// instead of repeating itself.
module prng_feedback
  import prng_pkg::*;
(
  input  prn_t state_i,
  output prn_t next_o
);

  always_comb begin
    next_o = {state_i[PRNG_W-2:0], ~(state_i[TAP_HI] ^ state_i[TAP_LO])};
`ifdef PRNG_LOCKUP_GUARD_EN
    // All-ones is a fixed point under XNOR feedback; escape to zero.
    if (state_i == LOCKUP_STATE) begin
      next_o = '0;
    end
`endif
  end

endmodule

// File: rtl/prng.sv
// prng: 10-bit maximal-length pseudo-random source (dither for the
// firing-angle logic). Period 1023; all values except 10'h3FF.
// Parameters:
//   RESET_VALUE  value loaded by SCLR (must not be 10'h3FF)
// Ports:
//   SYS_CLK  clock, rising edge
//   SCLR     synchronous active-high clear, highest priority
//   LOAD     load SEED, second priority
//   EN       advance one step, lowest priority
//   SEED     seed value
//   PRN      current LFSR state (register output)
// Macro PRNG_LOCKUP_GUARD_EN: when defined, a SEED of 10'h3FF loads zero and
// the lock-up state steps to zero, so the generator can never stick.
module prng
  import prng_pkg::*;
#(
  parameter prn_t RESET_VALUE = 10'h000
) (
  input  logic              SYS_CLK,
  input  logic              SCLR,
  input  logic              LOAD,
  input  logic              EN,
  input  logic [PRNG_W-1:0] SEED,
  output logic [PRNG_W-1:0] PRN
);

  prn_t prn_q;
  prn_t prn_d;
  prn_t step_val;
  prn_t seed_val;

  prng_feedback u_feedback (
    .state_i (prn_q),
    .next_o  (step_val)
  );

`ifdef PRNG_LOCKUP_GUARD_EN
  assign seed_val = guard_seed(SEED);
`else
  assign seed_val = SEED;
`endif

  always_comb begin
    prn_d = prn_q;
    if (LOAD) begin
      prn_d = seed_val;
    end else if (EN) begin
      prn_d = step_val;
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SCLR) begin
      prn_q <= RESET_VALUE;
    end else begin
      prn_q <= prn_d;
    end
  end

  assign PRN = prn_q;

endmodule

// File: tb/tb_prng.sv
// tb_prng: self-checking bench for prng. A reference model computes the
// sequence with integer arithmetic and the priority rules; directed test
// sequences and randomized control traffic are compared against it.
module tb_prng;
  import prng_pkg::*;

  localparam prn_t RV = 10'h000;

  logic SYS_CLK = 1'b0;
  logic SCLR    = 1'b0;
  logic LOAD    = 1'b0;
  logic EN      = 1'b0;
  prn_t SEED    = '0;
  prn_t PRN;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   model    = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  prng #(.RESET_VALUE(RV)) dut (
    .SYS_CLK (SYS_CLK),
    .SCLR    (SCLR),
    .LOAD    (LOAD),
    .EN      (EN),
    .SEED    (SEED),
    .PRN     (PRN)
  );

`ifdef PRNG_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // Shift left by one (doubling mod 1024) and append 1 - (b9 xor b6).
  function automatic int ref_step(input int v);
    int b9, b6;
    if (GUARD && v == 1023) return 0;
    b9 = (v / 512) % 2;
    b6 = (v / 64) % 2;
    return (v * 2) % 1024 + (1 - (b9 ^ b6));
  endfunction

  task automatic check(input string tag, input prn_t obs, input prn_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply controls, update the model, compare PRN to the model.
  task automatic drive(input string tag, input bit sclr, input bit load,
                       input bit en, input prn_t seed);
    SCLR = sclr;
    LOAD = load;
    EN   = en;
    SEED = seed;
    @(posedge SYS_CLK);
    #1;
    if (sclr)      model = int'(RV);
    else if (load) model = (GUARD && seed == 10'h3FF) ? 0 : int'(seed);
    else if (en)   model = ref_step(model);
    check(tag, PRN, prn_t'(model));
  endtask

  initial begin
    prn_t exp_run  [9] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                           10'h01F, 10'h03F, 10'h07F, 10'h0FE};
    prn_t exp_seed [6] = '{10'h005, 10'h00B, 10'h017, 10'h02F, 10'h05F,
                           10'h0BE};
    bit   seen [1024];
    int   dup;

    // Clear then run
    drive("clear", 1, 0, 1, 10'h155);
    check("clear_val", PRN, exp_run[0]);
    for (int i = 1; i < 9; i++) begin
      drive("run", 0, 0, 1, '0);
      check("run_seq", PRN, exp_run[i]);
    end

    // Seed load then run
    drive("load5", 0, 1, 0, 10'h005);
    check("load5_val", PRN, exp_seed[0]);
    for (int i = 1; i < 6; i++) begin
      drive("seed_run", 0, 0, 1, prn_t'($urandom));
      check("seed_seq", PRN, exp_seed[i]);
    end

    // Full period from 005
    drive("per_load", 0, 1, 0, 10'h005);
    foreach (seen[i]) seen[i] = 1'b0;
    seen[5] = 1'b1;
    dup = 0;
    for (int i = 1; i <= 1023; i++) begin
      drive("period", 0, 0, 1, '0);
      if (i < 1023) begin
        if (seen[PRN] || PRN == 10'h3FF) dup++;
        seen[PRN] = 1'b1;
      end
    end
    check("period_return", PRN, 10'h005);
    check("period_unique", prn_t'(dup), '0);

    // Priority
    drive("prio_all", 1, 1, 1, 10'h2AA);
    check("prio_all_val", PRN, 10'h000);
    drive("prio_le", 0, 1, 1, 10'h008);
    check("prio_le_val", PRN, 10'h008);
    drive("prio_step", 0, 0, 1, '0);
    check("prio_step_val", PRN, 10'h011);
    drive("hold", 0, 0, 0, 10'h3C3);
    check("hold_val", PRN, 10'h011);
    drive("hold2", 0, 0, 0, 10'h001);
    check("hold2_val", PRN, 10'h011);

    // Mid-run clear with EN held high
    drive("mid_load", 0, 1, 0, 10'h005);
    repeat (44) drive("mid_step", 0, 0, 1, '0);
    for (int i = 0; i < 46; i++) begin
      drive("mid_clr", 1, 0, 1, '0);
      check("mid_clr_val", PRN, 10'h000);
    end
    drive("mid_rel1", 0, 0, 1, '0);
    check("mid_rel1_val", PRN, 10'h001);
    drive("mid_rel2", 0, 0, 1, '0);
    check("mid_rel2_val", PRN, 10'h003);

    // Lock-up state
    drive("lock_load", 0, 1, 0, 10'h3FF);
    check("lock_load_val", PRN, GUARD ? 10'h000 : 10'h3FF);
    drive("lock_s1", 0, 0, 1, '0);
    check("lock_s1_val", PRN, GUARD ? 10'h001 : 10'h3FF);
    drive("lock_s2", 0, 0, 1, '0);
    check("lock_s2_val", PRN, GUARD ? 10'h003 : 10'h3FF);
    drive("lock_clr", 1, 0, 0, '0);

    // Randomized control traffic
    for (int i = 0; i < 600; i++) begin
      bit   r_clr, r_load, r_en;
      prn_t r_seed;
      r_clr  = ($urandom_range(0, 39) == 0);
      r_load = ($urandom_range(0, 15) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_seed = ($urandom_range(0, 7) == 0) ? 10'h3FF : prn_t'($urandom);
      drive("random", r_clr, r_load, r_en, r_seed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
